// File: rtl/moore_seq_detector.sv
// Serial Moore sequence detector with a runtime-loadable pattern and length,
// overlapping/non-overlapping match modes and a saturating match counter.
`timescale 1ns/1ps
module moore_seq_detector #(
  parameter int                 MAX_LEN     = 8,
  parameter int                 LEN_W       = $clog2(MAX_LEN + 1),
  parameter int                 CNT_W       = 8,
  parameter logic [MAX_LEN-1:0] DEF_PATTERN = 8'b0000_1010,
  parameter int                 DEF_LEN     = 4,
  parameter bit                 DEF_OVERLAP = 1'b1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in,
  input  logic               in_valid,
  input  logic               cfg_load,
  input  logic [MAX_LEN-1:0] cfg_pattern,
  input  logic [LEN_W-1:0]   cfg_len,
  input  logic               cfg_overlap,
  input  logic               cnt_clr,
  output logic               out,
  output logic [CNT_W-1:0]   match_count
);

  typedef enum logic {HUNT = 1'b0, MATCH = 1'b1} state_t;

  state_t             r_st;
  logic [MAX_LEN-1:0] r_hist;
  logic [MAX_LEN-1:0] r_pat;
  logic [LEN_W-1:0]   r_fill;
  logic [LEN_W-1:0]   r_len;
  logic               r_ovl;
  logic [CNT_W-1:0]   r_cnt;

  logic [MAX_LEN-1:0] w_hist_n;
  logic [MAX_LEN-1:0] w_mask;
  logic [LEN_W-1:0]   w_fill_n;
  logic [LEN_W-1:0]   w_cfg_len;
  logic               w_accept;
  logic               w_match;

  // Only the low r_len history bits take part in the comparison.
  always_comb begin
    w_mask = '0;
    for (int i = 0; i < MAX_LEN; i++) begin
      w_mask[i] = (LEN_W'(i) < r_len);
    end
  end

  always_comb begin
    w_cfg_len = cfg_len;
    if (cfg_len == '0) begin
      w_cfg_len = LEN_W'(1);
    end else if (cfg_len > LEN_W'(MAX_LEN)) begin
      w_cfg_len = LEN_W'(MAX_LEN);
    end
  end

  assign w_hist_n = {r_hist[MAX_LEN-2:0], in};
  assign w_fill_n = (r_fill >= LEN_W'(MAX_LEN)) ? r_fill : r_fill + LEN_W'(1);
  assign w_accept = in_valid && !cfg_load;
  assign w_match  = (w_fill_n >= r_len) && (((w_hist_n ^ r_pat) & w_mask) == '0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_st   <= HUNT;
      r_hist <= '0;
      r_fill <= '0;
      r_pat  <= DEF_PATTERN;
      r_len  <= LEN_W'(DEF_LEN);
      r_ovl  <= DEF_OVERLAP;
      r_cnt  <= '0;
    end else begin
      if (cfg_load) begin
        r_pat  <= cfg_pattern;
        r_len  <= w_cfg_len;
        r_ovl  <= cfg_overlap;
        r_hist <= '0;
        r_fill <= '0;
        r_st   <= HUNT;
      end else if (w_accept) begin
        r_hist <= w_hist_n;
        if (w_match) begin
          r_st   <= MATCH;
          // Non-overlapping mode demands a full fresh pattern after each hit.
          r_fill <= r_ovl ? w_fill_n : '0;
        end else begin
          r_st   <= HUNT;
          r_fill <= w_fill_n;
        end
      end

      if (cnt_clr) begin
        r_cnt <= '0;
      end else if (w_accept && w_match && (r_cnt != {CNT_W{1'b1}})) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  assign out         = (r_st == MATCH);
  assign match_count = r_cnt;

endmodule

// File: tb/tb_moore_seq_detector.sv
// Self-checking bench for moore_seq_detector: a bit-queue reference model feeds
// an expected queue that is compared one cycle after each driven vector.
`timescale 1ns/1ps
module tb_moore_seq_detector;

  localparam int MAX_LEN = 8;
  localparam int LEN_W   = 4;

  logic               clk = 1'b0;
  logic               rst;
  logic               in;
  logic               in_valid;
  logic               cfg_load;
  logic [MAX_LEN-1:0] cfg_pattern;
  logic [LEN_W-1:0]   cfg_len;
  logic               cfg_overlap;
  logic               cnt_clr;
  logic               out;
  logic [7:0]         match_count;
  logic               out_sat;
  logic [1:0]         match_count_sat;

  // Both instances see identical stimulus; the second has a 2-bit counter.
  moore_seq_detector #(.CNT_W(8)) dut (
    .clk(clk), .rst(rst), .in(in), .in_valid(in_valid), .cfg_load(cfg_load),
    .cfg_pattern(cfg_pattern), .cfg_len(cfg_len), .cfg_overlap(cfg_overlap),
    .cnt_clr(cnt_clr), .out(out), .match_count(match_count)
  );

  moore_seq_detector #(.CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst), .in(in), .in_valid(in_valid), .cfg_load(cfg_load),
    .cfg_pattern(cfg_pattern), .cfg_len(cfg_len), .cfg_overlap(cfg_overlap),
    .cnt_clr(cnt_clr), .out(out_sat), .match_count(match_count_sat)
  );

  // Clock / timeout
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish, expected finish before 500000ns");
    $fatal(1);
  end

  // Scoreboard and reference model
  logic [10:0] exp_q[$];
  int          n_vec = 0;
  int          n_err = 0;

  bit          m_bits[$];
  logic [7:0]  m_pat;
  int          m_len;
  bit          m_ovl;
  bit          m_out;
  int          m_cnt;
  int          m_cnt2;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_bits.delete();
    m_pat  = 8'b0000_1010;
    m_len  = 4;
    m_ovl  = 1'b1;
    m_out  = 1'b0;
    m_cnt  = 0;
    m_cnt2 = 0;
  endtask

  // Drive one cycle, predict its result, then compare just after the edge.
  task automatic step(input bit b, input bit v, input bit ld = 1'b0,
                      input logic [7:0] p = 8'h00, input logic [3:0] l = 4'd0,
                      input bit o = 1'b0, input bit clr = 1'b0);
    logic [10:0] e;
    bit          hit;
    in = b; in_valid = v; cfg_load = ld; cfg_pattern = p;
    cfg_len = l; cfg_overlap = o; cnt_clr = clr;
    if (ld) begin
      m_pat = p;
      m_len = (l == 4'd0) ? 1 : (l > 4'd8) ? 8 : int'(l);
      m_ovl = o;
      m_bits.delete();
      m_out = 1'b0;
    end else if (v) begin
      m_bits.push_back(b);
      if (m_bits.size() > 8) void'(m_bits.pop_front());
      hit = (m_bits.size() >= m_len);
      if (hit) begin
        for (int k = 0; k < m_len; k++) begin
          if (m_bits[m_bits.size() - 1 - k] != m_pat[k]) hit = 1'b0;
        end
      end
      m_out = hit;
      if (hit) begin
        if (m_cnt < 255) m_cnt++;
        if (m_cnt2 < 3) m_cnt2++;
        if (!m_ovl) m_bits.delete();
      end
    end
    if (clr) begin
      m_cnt  = 0;
      m_cnt2 = 0;
    end
    exp_q.push_back({m_out, m_cnt[7:0], m_cnt2[1:0]});
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      check("sb_empty", 32'd0, 32'd1);
    end else begin
      e = exp_q.pop_front();
      check("out", out, e[10]);
      check("cnt", match_count, e[9:2]);
      check("out_sat", out_sat, e[10]);
      check("cnt_sat", match_count_sat, e[1:0]);
    end
  endtask

  task automatic send_bits(input logic [15:0] bits, input int n);
    logic [15:0] v;
    v = bits;
    for (int i = n - 1; i >= 0; i--) step(v[i], 1'b1);
  endtask

  // Reset asserted between edges; outputs must fall before the next edge.
  task automatic mid_reset();
    in_valid = 1'b0; cfg_load = 1'b0; cnt_clr = 1'b0;
    #2 rst = 1'b0;
    #1;
    check("rst_out", out, 0);
    check("rst_cnt", match_count, 0);
    check("rst_out_sat", out_sat, 0);
    check("rst_cnt_sat", match_count_sat, 0);
    model_reset();
    #1 rst = 1'b1;
  endtask

  initial begin
    logic [15:0] stream;
    logic [7:0]  rp;
    logic [3:0]  rl;
    stream = 16'b0111_0010_1010_0100;
    rst = 1'b0; in = 1'b0; in_valid = 1'b0; cfg_load = 1'b0;
    cfg_pattern = '0; cfg_len = '0; cfg_overlap = 1'b0; cnt_clr = 1'b0;
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #1;
    check("reset_out", out, 0);
    check("reset_cnt", match_count, 0);
    rst = 1'b1;

    // Default pattern 1010, overlapping
    send_bits(stream, 15);
    check("defaults_cnt", match_count, 2);

    // Non-overlapping, counter cleared on the load cycle
    step(1'b0, 1'b0, 1'b1, 8'b1010, 4'd4, 1'b0, 1'b1);
    send_bits(stream, 15);
    check("nonovl_cnt", match_count, 1);

    // in_valid gaps, including a held cycle with in=1 that must be ignored
    step(1'b0, 1'b0, 1'b1, 8'b1010, 4'd4, 1'b1);
    step(1, 1); step(0, 0); step(0, 1); step(1, 0); step(1, 1);
    step(1, 0); step(0, 1); step(1, 0); step(0, 0); step(1, 0);
    check("gap_hold", out, 1);

    // Reload with a bit presented on the load cycle, then len clamping
    step(1'b1, 1'b1, 1'b1, 8'b111, 4'd3, 1'b1);
    step(1, 1); step(1, 1); step(1, 1); step(1, 1);
    check("reconf_cnt", match_count, 4);
    step(1'b0, 1'b0, 1'b1, 8'h01, 4'd0, 1'b1);
    step(1, 1); step(0, 1); step(1, 1);
    check("len0_out", out, 1);
    step(1'b0, 1'b0, 1'b1, 8'hA5, 4'd15, 1'b1);
    send_bits(16'h00A5, 8);
    check("len_max_out", out, 1);

    // Reset in the middle of activity restores the default configuration
    step(1'b0, 1'b0, 1'b1, 8'b101, 4'd3, 1'b1);
    send_bits(16'b101, 3);
    mid_reset();
    step(0, 1);
    check("post_rst_out", out, 0);
    send_bits(16'b1010, 4);
    check("post_rst_default", out, 1);

    // Saturation of the 2-bit counter and clear priority over increment
    step(1'b0, 1'b0, 1'b1, 8'h01, 4'd1, 1'b1, 1'b1);
    for (int i = 0; i < 5; i++) step(1, 1);
    check("sat_cnt", match_count_sat, 3);
    step(1'b1, 1'b1, 1'b0, 8'h00, 4'd0, 1'b0, 1'b1);
    check("clr_out", out, 1);
    check("clr_cnt", match_count, 0);

    // Random traffic under short random configurations
    for (int r = 0; r < 6; r++) begin
      rp = 8'($urandom_range(0, 255));
      rl = 4'($urandom_range(0, 4));
      step(1'b0, 1'b0, 1'b1, rp, rl, 1'($urandom_range(0, 1)));
      for (int i = 0; i < 60; i++) begin
        step(1'($urandom_range(0, 1)), ($urandom_range(0, 3) != 0),
             1'b0, 8'h00, 4'd0, 1'b0, ($urandom_range(0, 31) == 0));
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
